// File: rtl/vote_pkg.sv
// Shared types and constants for the four-voter majority session controller.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DONE    = 2'd3
  } vote_state_t;

  localparam int N_VOTERS       = 4;
  localparam int VOTE_THRESHOLD = 3;

endpackage

// File: rtl/maj4_eval.sv
// Combinational majority over the ballot register: 1 when at least
// VOTE_THRESHOLD of the N_VOTERS ballots are 1.
module maj4_eval
  import vote_pkg::*;
(
  input  logic [N_VOTERS-1:0] ballot,
  output logic                maj
);

  logic [2:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      ones = ones + {2'b00, ballot[i]};
    end
    maj = (ones >= 3'(VOTE_THRESHOLD));
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer: opens on start, latches one ballot per voter,
// closes on a full mask or timeout, then offers the majority decision.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter  int TIMEOUT = 16,
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic [3:0] vote_accept,
  output logic       busy,
  output logic       result,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [3:0] voted,
  output logic       timed_out,
  output logic [1:0] dbg_state
);

  // Handshakes: a ballot transfers on vote_valid[i] & vote_accept[i]; the
  // decision transfers on result_valid & result_ready, and result_valid
  // stays high with result/timed_out/voted stable until it does.

  vote_state_t   state_q, state_d;
  logic [3:0]    voted_q, voted_d;
  logic [3:0]    ballot_q, ballot_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          result_q, result_d;
  logic          timed_out_q, timed_out_d;
  logic          maj;

  maj4_eval u_maj4_eval (
    .ballot (ballot_q),
    .maj    (maj)
  );

  assign vote_accept  = vote_valid & {4{state_q == COLLECT}} & ~voted_q;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign voted        = voted_q;
  assign timed_out    = timed_out_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d     = state_q;
    voted_d     = voted_q;
    ballot_d    = ballot_q;
    timer_d     = timer_q;
    result_d    = result_q;
    timed_out_d = timed_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = COLLECT;
          voted_d     = '0;
          ballot_d    = '0;
          timer_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      COLLECT: begin
        voted_d  = voted_q | vote_accept;
        ballot_d = (ballot_q & ~vote_accept) | (vote_val & vote_accept);
        timer_d  = timer_q + TW'(1);
        // A full mask wins over timeout, so a last ballot on the timeout cycle is not a timeout.
        if (voted_d == 4'hF) begin
          state_d = DECIDE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d     = DECIDE;
          timed_out_d = 1'b1;
        end
      end
      DECIDE: begin
        result_d = maj;
        state_d  = DONE;
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      voted_q     <= '0;
      ballot_q    <= '0;
      timer_q     <= '0;
      result_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      voted_q     <= voted_d;
      ballot_q    <= ballot_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      timed_out_q <= timed_out_d;
    end
  end

endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Sequencing controller for the 4-input majority voter. It opens a voting session on `start` and collects at most one ballot per voter, with per-voter handshakes. The session closes when all four voters have voted or when a cycle timeout expires. The controller then evaluates the ballots (pass = at least 3 of 4 ones; missing ballots count as 0) and presents the result through a valid/ready handshake. It sits between asynchronous ballot sources and any downstream consumer of the decision.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles spent in COLLECT; legal range 2..65535.
- `TW`, default `$clog2(TIMEOUT)`: timer width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request to open a session; honoured only in IDLE.
- `vote_valid`  in  4  per-voter ballot strobe; bit i belongs to voter i.
- `vote_val`  in  4  per-voter ballot value, sampled when the matching `vote_accept` bit is 1.
- `vote_accept`  out  4  combinational: `vote_valid[i] & (state==COLLECT) & ~voted[i]`.
- `busy`  out  1  high in COLLECT, DECIDE, DONE.
- `result`  out  1  majority decision; meaningful while `result_valid`=1.
- `result_valid`  out  1  high in DONE.
- `result_ready`  in  1  consumer accepts the result.
- `voted`  out  4  mask of voters whose ballot has been latched this session.
- `timed_out`  out  1  session closed by timeout; valid while `result_valid`=1.

## Operation
- FSM states: IDLE, COLLECT, DECIDE, DONE.
- IDLE → COLLECT on `start`. On entry, clear `voted`, ballots and timer, and clear `timed_out`.
- COLLECT:
  - Each cycle, every accepted voter i latches `ballot[i]<=vote_val[i]` and `voted[i]<=1`.
  - Repeat strobes from a voter that has already voted are ignored.
  - The timer increments every COLLECT cycle.
- COLLECT → DECIDE when `(voted | accepted)==4'hF`.
- COLLECT → DECIDE with `timed_out<=1` when the timer equals `TIMEOUT-1` and the mask is not full.
- If the fourth ballot arrives on the timeout cycle, `timed_out` stays 0.
- Ballots accepted on the closing cycle always count.
- DECIDE lasts exactly 1 cycle:
  - `result <= maj4(ballot)`, where unvoted positions are 0.
  - → DONE.
- DONE: `result`, `timed_out` and `voted` are held stable.
  - On `result_ready`=1 → IDLE.
  - `start` is ignored in DONE, including on the same cycle as `result_ready`.
- `start` is ignored in COLLECT, DECIDE and DONE. It is not queued.
- `vote_valid` outside COLLECT is ignored and gets no accept.
- Reset, asynchronous and possibly mid-session:
  - state=IDLE.
  - `voted`=0, ballots=0, timer=0.
  - `result`=0, `result_valid`=0, `timed_out`=0, `busy`=0.
  - `vote_accept`=0, since it is a function of state.

## Timing
- `start` sampled at edge 0 → COLLECT from cycle 1. The first ballots are accepted in cycle 1.
- Last ballot accepted in cycle k → DECIDE in k+1 → `result_valid`=1 in k+2.
- Minimum start-to-result latency: 3 cycles, when all four voters vote in cycle 1.
- Timeout path:
  - COLLECT occupies cycles 1..TIMEOUT.
  - DECIDE is at cycle TIMEOUT+1.
  - `result_valid` rises at cycle TIMEOUT+2.
- Result handshake completes on the edge where `result_valid & result_ready` are both 1. `result_valid` is 0 in the following cycle.
- The earliest next `start` is sampled in the first IDLE cycle after the handshake.

## Structure
- Package `vote_pkg`:
  - `typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} vote_state_t`.
  - `localparam int N_VOTERS = 4`.
  - `localparam int VOTE_THRESHOLD = 3`.
- Sub-module `maj4_eval`: purely combinational 4-input majority (≥3 ones → 1), instantiated once on the ballot register.
- Top-level content:
  - FSM.
  - `TW`-bit timer.
  - 4-bit `voted` and ballot registers.
  - Result and `timed_out` flops.

## Test plan
- Full pass: `start`; cycle 1 `vote_valid`=F, `vote_val`=E.
  - `vote_accept`=F; `result_valid` at cycle 3 with `result`=1, `timed_out`=0.
  - With `result_ready` held 0 for 5 cycles, outputs hold, then return to IDLE.
- Staggered and repeat votes: voter0=1 at cycle 2; voter0=0 again at cycle 3; voters 1,2,3 = 0,1,0 at cycles 4,5,6.
  - Cycle 3 accept is 0; ballot0 stays 1.
  - Result = 0 (2 of 4) at cycle 8.
- Timeout: `TIMEOUT`=16; only voters 0,1,2 vote 1 at cycle 1.
  - DECIDE at cycle 17; `result_valid` at 18; `result`=1; `timed_out`=1; `voted`=7.
- Simultaneous events:
  - Voter 3 votes on cycle 16 (the timeout cycle) → `timed_out`=0, `voted`=F.
  - `start` asserted during COLLECT/DONE, and together with `result_ready`, → no new session.
- Reset mid-operation: assert `rst_n`=0 in COLLECT after 2 ballots.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a new session starts with `voted`=0.
- Votes while idle: `vote_valid`=F in IDLE → `vote_accept`=0 and no state change.
